// File: rtl/mac_rx_frame_fifo.sv
// Store-and-forward receive buffer: bytes land in a circular RAM and only frames
// confirmed by CRC status are released to the valid/ready output stream.
module mac_rx_frame_fifo #(
    parameter int ADDR_W      = 11,
    parameter int STATUS_WAIT = 4
) (
    input  logic        p_in_clk,
    input  logic        p_in_rstn,
    input  logic [7:0]  p_in_rx_data,
    input  logic        p_in_rx_valid,
    input  logic        p_in_rx_sof,
    input  logic        p_in_rx_eof,
    input  logic        p_in_rx_crc_good,
    input  logic        p_in_rx_fr_err,
    output logic [7:0]  p_out_tdata,
    output logic        p_out_tvalid,
    output logic        p_out_tlast,
    input  logic        p_in_tready,
    output logic [15:0] p_out_frm_ok,
    output logic [15:0] p_out_frm_drop,
    output logic        p_out_ovf
);

    localparam int PTR_W = ADDR_W + 1;
    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = (STATUS_WAIT < 2) ? 1 : $clog2(STATUS_WAIT + 1);
    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STATUS_WAIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_WAIT = 2'd2,
        ST_DROP = 2'd3
    } state_t;

    state_t             state_reg, state_next;
    logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]   cm_ptr_reg, cm_ptr_next;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [CNT_W-1:0]   wait_cnt_reg;
    logic [15:0]        frm_ok_reg, frm_drop_reg;
    logic               ovf_reg;
    logic               tvalid_reg;
    logic [8:0]         rd_word_reg;

    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic [8:0]         wr_word;
    logic               ok_inc;
    logic [1:0]         drop_inc;
    logic               ovf_next;

    logic [8:0] ram_mem [DEPTH];

    logic sof_v, eof_v, start_full, cur_full, expire, start_frame, rd_load;
    logic [16:0] drop_sum;

    assign sof_v      = p_in_rx_valid & p_in_rx_sof;
    assign eof_v      = p_in_rx_valid & p_in_rx_eof;
    // A new frame always starts at cm_ptr, so its space check is against cm_ptr.
    assign start_full = (cm_ptr_reg - rd_ptr_reg) == DEPTH_P;
    assign cur_full   = (wr_ptr_reg - rd_ptr_reg) == DEPTH_P;
    assign expire     = wait_cnt_reg == CNT_LAST;
    assign start_frame = sof_v & ((state_reg == ST_IDLE) |
                                  ((state_reg == ST_RECV) & ~p_in_rx_fr_err));

    always_ff @(posedge p_in_clk or negedge p_in_rstn) begin
        if (!p_in_rstn) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (start_frame) begin
            if (start_full) begin
                state_next = eof_v ? ST_IDLE : ST_DROP;
            end else if (eof_v) begin
                state_next = (p_in_rx_fr_err | p_in_rx_crc_good) ? ST_IDLE : ST_WAIT;
            end else begin
                state_next = ST_RECV;
            end
        end else begin
            case (state_reg)
                ST_RECV: begin
                    if (p_in_rx_fr_err) begin
                        state_next = eof_v ? ST_IDLE : ST_DROP;
                    end else if (p_in_rx_valid) begin
                        if (cur_full) begin
                            state_next = eof_v ? ST_IDLE : ST_DROP;
                        end else if (eof_v) begin
                            state_next = p_in_rx_crc_good ? ST_IDLE : ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (p_in_rx_fr_err | p_in_rx_crc_good | expire) begin
                        state_next = ST_IDLE;
                    end
                end
                ST_DROP: begin
                    if (eof_v) begin
                        state_next = ST_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        wr_en       = 1'b0;
        wr_addr     = wr_ptr_reg[ADDR_W-1:0];
        wr_word     = {p_in_rx_eof, p_in_rx_data};
        wr_ptr_next = wr_ptr_reg;
        cm_ptr_next = cm_ptr_reg;
        ok_inc      = 1'b0;
        drop_inc    = 2'd0;
        ovf_next    = 1'b0;
        if (start_frame) begin
            // A sof inside RECV means the previous frame lost its eof: discard it.
            if (state_reg == ST_RECV) begin
                drop_inc = 2'd1;
            end
            wr_ptr_next = cm_ptr_reg;
            wr_addr     = cm_ptr_reg[ADDR_W-1:0];
            if (start_full) begin
                ovf_next = 1'b1;
                if (eof_v) begin
                    drop_inc = drop_inc + 2'd1;
                end
            end else if (eof_v && p_in_rx_fr_err) begin
                drop_inc = drop_inc + 2'd1;
            end else begin
                wr_en       = 1'b1;
                wr_ptr_next = cm_ptr_reg + PTR_ONE;
                if (eof_v && p_in_rx_crc_good) begin
                    cm_ptr_next = cm_ptr_reg + PTR_ONE;
                    ok_inc      = 1'b1;
                end
            end
        end else begin
            case (state_reg)
                ST_RECV: begin
                    if (p_in_rx_fr_err) begin
                        if (eof_v) begin
                            wr_ptr_next = cm_ptr_reg;
                            drop_inc    = 2'd1;
                        end
                    end else if (p_in_rx_valid) begin
                        if (cur_full) begin
                            ovf_next = 1'b1;
                            if (eof_v) begin
                                wr_ptr_next = cm_ptr_reg;
                                drop_inc    = 2'd1;
                            end
                        end else begin
                            wr_en       = 1'b1;
                            wr_ptr_next = wr_ptr_reg + PTR_ONE;
                            if (eof_v && p_in_rx_crc_good) begin
                                cm_ptr_next = wr_ptr_reg + PTR_ONE;
                                ok_inc      = 1'b1;
                            end
                        end
                    end
                end
                ST_WAIT: begin
                    // fr_err wins over crc_good; crc_good wins over window expiry.
                    if (p_in_rx_fr_err || (!p_in_rx_crc_good && expire)) begin
                        wr_ptr_next = cm_ptr_reg;
                        drop_inc    = 2'd1;
                    end else if (p_in_rx_crc_good) begin
                        cm_ptr_next = wr_ptr_reg;
                        ok_inc      = 1'b1;
                    end
                end
                ST_DROP: begin
                    if (eof_v) begin
                        wr_ptr_next = cm_ptr_reg;
                        drop_inc    = 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign drop_sum = 17'(frm_drop_reg) + 17'(drop_inc);

    always_ff @(posedge p_in_clk or negedge p_in_rstn) begin
        if (!p_in_rstn) begin
            wr_ptr_reg   <= '0;
            cm_ptr_reg   <= '0;
            wait_cnt_reg <= '0;
            frm_ok_reg   <= '0;
            frm_drop_reg <= '0;
            ovf_reg      <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            cm_ptr_reg <= cm_ptr_next;
            ovf_reg    <= ovf_next;
            if (state_reg != ST_WAIT) begin
                wait_cnt_reg <= '0;
            end else begin
                wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
            end
            if (ok_inc && (frm_ok_reg != 16'hFFFF)) begin
                frm_ok_reg <= frm_ok_reg + 16'd1;
            end
            frm_drop_reg <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    always_ff @(posedge p_in_clk) begin
        if (wr_en) begin
            ram_mem[wr_addr] <= wr_word;
        end
    end

    // The registered RAM read doubles as the output register; it only loads
    // when empty or when the current byte is being accepted, so it holds on stall.
    assign rd_load = (rd_ptr_reg != cm_ptr_reg) && (!tvalid_reg || p_in_tready);

    always_ff @(posedge p_in_clk) begin
        if (rd_load) begin
            rd_word_reg <= ram_mem[rd_ptr_reg[ADDR_W-1:0]];
        end
    end

    always_ff @(posedge p_in_clk or negedge p_in_rstn) begin
        if (!p_in_rstn) begin
            rd_ptr_reg <= '0;
            tvalid_reg <= 1'b0;
        end else if (rd_load) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            tvalid_reg <= 1'b1;
        end else if (p_in_tready) begin
            tvalid_reg <= 1'b0;
        end
    end

    // Masking with tvalid gives zero outputs after reset without resetting the RAM read register.
    assign p_out_tvalid   = tvalid_reg;
    assign p_out_tdata    = rd_word_reg[7:0] & {8{tvalid_reg}};
    assign p_out_tlast    = rd_word_reg[8] & tvalid_reg;
    assign p_out_frm_ok   = frm_ok_reg;
    assign p_out_frm_drop = frm_drop_reg;
    assign p_out_ovf      = ovf_reg;

endmodule

// File: tb/tb_mac_rx_frame_fifo.sv
// Directed bench for mac_rx_frame_fifo: a 512-byte instance for most scenarios
// and a 64-byte instance for the overflow scenario, fed from the same MAC stream.
module tb_mac_rx_frame_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_sof, rx_eof, rx_crc_good, rx_fr_err;
    logic        tready_fix, rnd_en, tready_s;
    logic        rnd_bit = 1'b1;
    logic        tready_m;

    logic [7:0]  m_tdata, s_tdata;
    logic        m_tvalid, m_tlast, s_tvalid, s_tlast;
    logic [15:0] m_frm_ok, m_frm_drop, s_frm_ok, s_frm_drop;
    logic        m_ovf, s_ovf;

    int tests = 0;
    int fails = 0;

    logic [8:0] q_m[$];
    logic [8:0] q_s[$];
    int ovf_s_cnt = 0;

    assign tready_m = rnd_en ? rnd_bit : tready_fix;

    mac_rx_frame_fifo #(.ADDR_W(9), .STATUS_WAIT(4)) dut_m (
        .p_in_clk(clk), .p_in_rstn(rstn),
        .p_in_rx_data(rx_data), .p_in_rx_valid(rx_valid), .p_in_rx_sof(rx_sof),
        .p_in_rx_eof(rx_eof), .p_in_rx_crc_good(rx_crc_good), .p_in_rx_fr_err(rx_fr_err),
        .p_out_tdata(m_tdata), .p_out_tvalid(m_tvalid), .p_out_tlast(m_tlast),
        .p_in_tready(tready_m), .p_out_frm_ok(m_frm_ok), .p_out_frm_drop(m_frm_drop),
        .p_out_ovf(m_ovf)
    );

    mac_rx_frame_fifo #(.ADDR_W(6), .STATUS_WAIT(4)) dut_s (
        .p_in_clk(clk), .p_in_rstn(rstn),
        .p_in_rx_data(rx_data), .p_in_rx_valid(rx_valid), .p_in_rx_sof(rx_sof),
        .p_in_rx_eof(rx_eof), .p_in_rx_crc_good(rx_crc_good), .p_in_rx_fr_err(rx_fr_err),
        .p_out_tdata(s_tdata), .p_out_tvalid(s_tvalid), .p_out_tlast(s_tlast),
        .p_in_tready(tready_s), .p_out_frm_ok(s_frm_ok), .p_out_frm_drop(s_frm_drop),
        .p_out_ovf(s_ovf)
    );

    always begin
        @(posedge clk);
        #1;
        rnd_bit = 1'($urandom_range(0, 1));
    end

    // Accepted bytes are captured on the falling edge, ahead of the accepting rising edge.
    always @(negedge clk) begin
        if (rstn) begin
            if (m_tvalid && tready_m) q_m.push_back({m_tlast, m_tdata});
            if (s_tvalid && tready_s) q_s.push_back({s_tlast, s_tdata});
            if (s_ovf) ovf_s_cnt++;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic idle();
        rx_valid = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0;
        rx_crc_good = 1'b0; rx_fr_err = 1'b0; rx_data = 8'h00;
    endtask

    // mode: 0 no status, 1 crc_good, 2 fr_err; dly: cycles after the eof byte (0 = eof cycle)
    task automatic send_frame(input int len, input int first, input int mode, input int dly, input bit with_eof);
        for (int i = 0; i < len; i++) begin
            @(posedge clk); #1;
            idle();
            rx_valid = 1'b1;
            rx_data  = 8'(first + i);
            rx_sof   = (i == 0);
            rx_eof   = with_eof && (i == len - 1);
            if (with_eof && i == len - 1 && dly == 0) begin
                rx_crc_good = (mode == 1);
                rx_fr_err   = (mode == 2);
            end
        end
        for (int c = 1; c <= dly; c++) begin
            @(posedge clk); #1;
            idle();
            if (c == dly) begin
                rx_crc_good = (mode == 1);
                rx_fr_err   = (mode == 2);
            end
        end
        @(posedge clk); #1;
        idle();
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        idle();
        rnd_en = 1'b0; tready_fix = 1'b1; tready_s = 1'b1;
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        idle();
        rnd_en = 1'b0; tready_fix = 1'b1; tready_s = 1'b1;
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        tests++; if (m_tvalid !== 1'b0) begin fails++; $display("FAIL reset_tvalid got %0b want 0", m_tvalid); end
        tests++; if (m_tdata !== 8'h00) begin fails++; $display("FAIL reset_tdata got %02h want 00", m_tdata); end
        tests++; if (m_tlast !== 1'b0) begin fails++; $display("FAIL reset_tlast got %0b want 0", m_tlast); end
        tests++; if (m_frm_ok !== 16'd0) begin fails++; $display("FAIL reset_frm_ok got %0d want 0", m_frm_ok); end
        tests++; if (m_frm_drop !== 16'd0) begin fails++; $display("FAIL reset_frm_drop got %0d want 0", m_frm_drop); end
        tests++; if (m_ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf got %0b want 0", m_ovf); end
        @(posedge clk); #1 rstn = 1'b1;
        repeat (3) @(negedge clk);
        tests++; if (m_tvalid !== 1'b0) begin fails++; $display("FAIL reset_idle_tvalid got %0b want 0", m_tvalid); end
        $display("[TB] reset checked");
    endtask

    // 1-byte frame with crc_good in its own cycle: byte must appear exactly 2 cycles later.
    task automatic test_latency();
        @(posedge clk); #1;
        rx_valid = 1'b1; rx_data = 8'hA5; rx_sof = 1'b1; rx_eof = 1'b1; rx_crc_good = 1'b1;
        @(negedge clk);
        tests++; if (m_tvalid !== 1'b0) begin fails++; $display("FAIL lat_c0_tvalid got %0b want 0", m_tvalid); end
        @(posedge clk); #1 idle();
        @(negedge clk);
        tests++; if (m_tvalid !== 1'b0) begin fails++; $display("FAIL lat_c1_tvalid got %0b want 0", m_tvalid); end
        tests++; if (m_frm_ok !== 16'd1) begin fails++; $display("FAIL lat_frm_ok got %0d want 1", m_frm_ok); end
        @(negedge clk);
        tests++; if (m_tvalid !== 1'b1) begin fails++; $display("FAIL lat_c2_tvalid got %0b want 1", m_tvalid); end
        tests++; if ({m_tlast, m_tdata} !== 9'h1A5) begin fails++; $display("FAIL lat_c2_word got %03h want 1a5", {m_tlast, m_tdata}); end
        repeat (3) @(negedge clk);
        $display("[TB] 1-byte frame latency checked");
    endtask

    task automatic test_good_frame();
        int base, bad;
        logic [8:0] exp;
        do_reset();
        base = q_m.size();
        send_frame(64, 0, 1, 2, 1'b1);
        for (int c = 0; c < 300 && q_m.size() < base + 64; c++) @(negedge clk);
        repeat (5) @(negedge clk);
        tests++; if (q_m.size() != base + 64) begin fails++; $display("FAIL good_len got %0d want 64", q_m.size() - base); end
        else begin
            bad = -1;
            for (int i = 0; i < 64; i++) begin
                exp = {(i == 63), 8'(i)};
                if (q_m[base + i] !== exp && bad < 0) bad = i;
            end
            tests++; if (bad >= 0) begin fails++; $display("FAIL good_data idx %0d got %03h want %03h", bad, q_m[base + bad], {(bad == 63), 8'(bad)}); end
        end
        tests++; if (m_frm_ok !== 16'd1) begin fails++; $display("FAIL good_frm_ok got %0d want 1", m_frm_ok); end
        tests++; if (m_frm_drop !== 16'd0) begin fails++; $display("FAIL good_frm_drop got %0d want 0", m_frm_drop); end
        $display("[TB] 64-byte good frame checked");
    endtask

    task automatic test_fr_err();
        int base, bad;
        logic [8:0] exp;
        do_reset();
        base = q_m.size();
        send_frame(64, 0, 2, 0, 1'b1);
        repeat (20) @(negedge clk);
        tests++; if (q_m.size() != base) begin fails++; $display("FAIL frerr_out got %0d bytes want 0", q_m.size() - base); end
        tests++; if (m_frm_drop !== 16'd1) begin fails++; $display("FAIL frerr_drop got %0d want 1", m_frm_drop); end
        tests++; if (m_frm_ok !== 16'd0) begin fails++; $display("FAIL frerr_ok got %0d want 0", m_frm_ok); end
        send_frame(60, 8'h40, 1, 1, 1'b1);
        for (int c = 0; c < 300 && q_m.size() < base + 60; c++) @(negedge clk);
        repeat (5) @(negedge clk);
        tests++; if (q_m.size() != base + 60) begin fails++; $display("FAIL frerr_next_len got %0d want 60", q_m.size() - base); end
        else begin
            bad = -1;
            for (int i = 0; i < 60; i++) begin
                exp = {(i == 59), 8'(8'h40 + i)};
                if (q_m[base + i] !== exp && bad < 0) bad = i;
            end
            tests++; if (bad >= 0) begin fails++; $display("FAIL frerr_next_data idx %0d got %03h want %03h", bad, q_m[base + bad], {(bad == 59), 8'(8'h40 + bad)}); end
        end
        tests++; if (m_frm_ok !== 16'd1) begin fails++; $display("FAIL frerr_next_ok got %0d want 1", m_frm_ok); end
        $display("[TB] fr_err frame dropped, following frame checked");
    endtask

    task automatic test_status_window();
        int base, bad;
        logic [8:0] exp;
        do_reset();
        base = q_m.size();
        send_frame(64, 0, 0, 0, 1'b1);
        repeat (4) @(negedge clk);
        tests++; if (m_frm_drop !== 16'd0) begin fails++; $display("FAIL win_drop_early got %0d want 0", m_frm_drop); end
        @(negedge clk);
        tests++; if (m_frm_drop !== 16'd1) begin fails++; $display("FAIL win_drop_expire got %0d want 1", m_frm_drop); end
        repeat (10) @(negedge clk);
        tests++; if (q_m.size() != base) begin fails++; $display("FAIL win_nostatus_out got %0d bytes want 0", q_m.size() - base); end
        send_frame(20, 8'h30, 1, 4, 1'b1);
        for (int c = 0; c < 100 && q_m.size() < base + 20; c++) @(negedge clk);
        repeat (5) @(negedge clk);
        tests++; if (m_frm_ok !== 16'd1) begin fails++; $display("FAIL win_last_cycle_ok got %0d want 1", m_frm_ok); end
        tests++; if (q_m.size() != base + 20) begin fails++; $display("FAIL win_last_cycle_len got %0d want 20", q_m.size() - base); end
        else begin
            bad = -1;
            for (int i = 0; i < 20; i++) begin
                exp = {(i == 19), 8'(8'h30 + i)};
                if (q_m[base + i] !== exp && bad < 0) bad = i;
            end
            tests++; if (bad >= 0) begin fails++; $display("FAIL win_last_cycle_data idx %0d got %03h want %03h", bad, q_m[base + bad], {(bad == 19), 8'(8'h30 + bad)}); end
        end
        send_frame(20, 8'h50, 1, 5, 1'b1);
        repeat (20) @(negedge clk);
        tests++; if (m_frm_drop !== 16'd2) begin fails++; $display("FAIL win_late_drop got %0d want 2", m_frm_drop); end
        tests++; if (q_m.size() != base + 20) begin fails++; $display("FAIL win_late_out got %0d bytes want 20", q_m.size() - base); end
        $display("[TB] status window boundaries checked");
    endtask

    task automatic test_overflow();
        int base, o0, bad;
        logic [8:0] exp;
        do_reset();
        tready_s = 1'b0;
        base = q_s.size();
        o0 = ovf_s_cnt;
        send_frame(40, 0, 1, 1, 1'b1);
        send_frame(40, 8'h80, 1, 1, 1'b1);
        repeat (10) @(negedge clk);
        tests++; if (ovf_s_cnt - o0 != 1) begin fails++; $display("FAIL ovf_pulses got %0d want 1", ovf_s_cnt - o0); end
        tests++; if (s_frm_ok !== 16'd1) begin fails++; $display("FAIL ovf_frm_ok got %0d want 1", s_frm_ok); end
        tests++; if (s_frm_drop !== 16'd1) begin fails++; $display("FAIL ovf_frm_drop got %0d want 1", s_frm_drop); end
        tests++; if (s_tvalid !== 1'b1 || s_tdata !== 8'h00) begin fails++; $display("FAIL ovf_held got v=%0b d=%02h want v=1 d=00", s_tvalid, s_tdata); end
        @(posedge clk); #1 tready_s = 1'b1;
        for (int c = 0; c < 200 && q_s.size() < base + 40; c++) @(negedge clk);
        repeat (20) @(negedge clk);
        tests++; if (q_s.size() != base + 40) begin fails++; $display("FAIL ovf_out_len got %0d want 40", q_s.size() - base); end
        else begin
            bad = -1;
            for (int i = 0; i < 40; i++) begin
                exp = {(i == 39), 8'(i)};
                if (q_s[base + i] !== exp && bad < 0) bad = i;
            end
            tests++; if (bad >= 0) begin fails++; $display("FAIL ovf_out_data idx %0d got %03h want %03h", bad, q_s[base + bad], {(bad == 39), 8'(bad)}); end
        end
        $display("[TB] overflow on 64-byte buffer checked");
    endtask

    task automatic test_truncation();
        int base, bad;
        logic [8:0] exp;
        do_reset();
        base = q_m.size();
        send_frame(10, 8'h10, 0, 0, 1'b0);
        send_frame(50, 8'h20, 1, 1, 1'b1);
        for (int c = 0; c < 200 && q_m.size() < base + 50; c++) @(negedge clk);
        repeat (5) @(negedge clk);
        tests++; if (m_frm_drop !== 16'd1) begin fails++; $display("FAIL trunc_drop got %0d want 1", m_frm_drop); end
        tests++; if (m_frm_ok !== 16'd1) begin fails++; $display("FAIL trunc_ok got %0d want 1", m_frm_ok); end
        tests++; if (q_m.size() != base + 50) begin fails++; $display("FAIL trunc_len got %0d want 50", q_m.size() - base); end
        else begin
            bad = -1;
            for (int i = 0; i < 50; i++) begin
                exp = {(i == 49), 8'(8'h20 + i)};
                if (q_m[base + i] !== exp && bad < 0) bad = i;
            end
            tests++; if (bad >= 0) begin fails++; $display("FAIL trunc_data idx %0d got %03h want %03h", bad, q_m[base + bad], {(bad == 49), 8'(8'h20 + bad)}); end
        end
        $display("[TB] truncated frame dropped, restarted frame checked");
    endtask

    task automatic test_back_to_back();
        int base, bad, base2;
        logic [8:0] exp;
        do_reset();
        rnd_en = 1'b1;
        base = q_m.size();
        for (int k = 0; k < 30; k++) begin
            // keep at most three frames in flight so the 512-byte buffer never fills
            for (int c = 0; c < 3000 && (q_m.size() - base) < (k - 3) * 100; c++) @(negedge clk);
            send_frame(100, k * 7, 1, 0, 1'b1);
        end
        for (int c = 0; c < 10000 && q_m.size() < base + 3000; c++) @(negedge clk);
        repeat (5) @(negedge clk);
        tests++; if (q_m.size() != base + 3000) begin fails++; $display("FAIL b2b_len got %0d want 3000", q_m.size() - base); end
        else begin
            for (int k = 0; k < 30; k++) begin
                bad = -1;
                for (int i = 0; i < 100; i++) begin
                    exp = {(i == 99), 8'(k * 7 + i)};
                    if (q_m[base + k * 100 + i] !== exp && bad < 0) bad = i;
                end
                tests++;
                if (bad >= 0) begin
                    fails++;
                    $display("FAIL b2b_frame %0d idx %0d got %03h want %03h", k, bad, q_m[base + k * 100 + bad], {(bad == 99), 8'(k * 7 + bad)});
                end else begin
                    $display("[TB] b2b frame %0d: 100 bytes in order", k);
                end
            end
        end
        tests++; if (m_frm_ok !== 16'd30) begin fails++; $display("FAIL b2b_frm_ok got %0d want 30", m_frm_ok); end
        tests++; if (m_frm_drop !== 16'd0) begin fails++; $display("FAIL b2b_frm_drop got %0d want 0", m_frm_drop); end

        rnd_en = 1'b0;
        tready_fix = 1'b0;
        send_frame(20, 8'h60, 1, 0, 1'b1);
        repeat (5) @(negedge clk);
        tests++; if (m_tvalid !== 1'b1) begin fails++; $display("FAIL rst_pre_tvalid got %0b want 1", m_tvalid); end
        tests++; if (m_frm_ok !== 16'd31) begin fails++; $display("FAIL rst_pre_ok got %0d want 31", m_frm_ok); end
        base2 = q_m.size();
        @(posedge clk); #1;
        rx_valid = 1'b1; rx_sof = 1'b1; rx_data = 8'hC0;
        @(posedge clk); #1;
        rx_sof = 1'b0; rx_data = 8'hC1;
        #2 rstn = 1'b0;
        #1;
        tests++; if (m_tvalid !== 1'b0) begin fails++; $display("FAIL rst_async_tvalid got %0b want 0", m_tvalid); end
        tests++; if (m_tdata !== 8'h00) begin fails++; $display("FAIL rst_async_tdata got %02h want 00", m_tdata); end
        tests++; if (m_frm_ok !== 16'd0) begin fails++; $display("FAIL rst_async_ok got %0d want 0", m_frm_ok); end
        tests++; if (m_frm_drop !== 16'd0) begin fails++; $display("FAIL rst_async_drop got %0d want 0", m_frm_drop); end
        idle();
        @(posedge clk); #1 rstn = 1'b1;
        tready_fix = 1'b1;
        repeat (20) @(negedge clk);
        tests++; if (q_m.size() != base2) begin fails++; $display("FAIL rst_discard got %0d bytes want 0", q_m.size() - base2); end
        $display("[TB] back-to-back with wrap and mid-frame reset checked");
    endtask

    initial begin
        rstn = 1'b0;
        test_reset();
        test_latency();
        test_good_frame();
        test_fr_err();
        test_status_window();
        test_overflow();
        test_truncation();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mac_rx_frame_fifo.md
Name: mac_rx_frame_fifo

Overview:
- Store-and-forward receive buffer directly downstream of mac_rgmii, in the mac_rx_clk_o domain of each Ethernet channel.
- Writes every received byte into a circular RAM, then decides per frame:
  - commits the frame if CRC-good status arrives for it;
  - rewinds and discards it on frame error, missing CRC status, truncation or overflow.
- Presents only complete, good frames on a valid/ready byte stream with tlast, and counts committed and dropped frames.

Parameters:
- ADDR_W, 11, RAM address width; depth = 2^ADDR_W bytes (2048 = one max frame plus margin).
- STATUS_WAIT, 4, cycles after the eof byte to wait for crc_good/fr_err before dropping the frame.

Ports:
- p_in_clk  in  1  clock; connected to mac_rx_clk_o.
- p_in_rstn  in  1  reset, asynchronous, active-low.
- p_in_rx_data  in  8  byte from MAC.
- p_in_rx_valid  in  1  byte qualifier.
- p_in_rx_sof  in  1  first byte of frame, qualified by valid.
- p_in_rx_eof  in  1  last byte of frame, qualified by valid.
- p_in_rx_crc_good  in  1  single-cycle pulse, CRC correct.
- p_in_rx_fr_err  in  1  single-cycle pulse, frame error.
- p_out_tdata  out  8  output byte.
- p_out_tvalid  out  1  output byte valid.
- p_out_tlast  out  1  last byte of frame.
- p_in_tready  in  1  downstream accept.
- p_out_frm_ok  out  16  committed-frame counter, saturating.
- p_out_frm_drop  out  16  dropped-frame counter, saturating.
- p_out_ovf  out  1  one-cycle pulse when a frame is dropped for lack of space.

Behaviour:
- Reset (async, rstn=0):
  - all pointers = 0; FSM = IDLE;
  - tvalid = 0, tdata = 0, tlast = 0;
  - both counters = 0; ovf = 0.
- Storage and pointers:
  - RAM is 9 bits wide ({eof_flag, byte}), 2^ADDR_W deep.
  - Pointers are ADDR_W+1 bits (wrap bit): wr_ptr, cm_ptr (commit), rd_ptr.
  - used = wr_ptr - rd_ptr (modulo 2^(ADDR_W+1)); full when used = 2^ADDR_W.
- Write FSM:
  - IDLE:
    - valid&sof → write byte at wr_ptr, wr_ptr+1, go to RECV.
    - valid without sof → ignore the byte.
    - valid&sof&eof (1-byte frame) → write with eof_flag=1, go to WAIT_STATUS.
  - RECV:
    - valid → write byte, wr_ptr+1; eof_flag = eof.
    - eof → go to WAIT_STATUS.
    - valid&sof (eof missing) → discard the partial frame (wr_ptr := cm_ptr, drop+1), then restart the frame with this byte.
    - fr_err pulse → go to DROP.
  - WAIT_STATUS:
    - crc_good seen in the eof cycle or within STATUS_WAIT cycles after → cm_ptr := wr_ptr, frm_ok+1, go to IDLE.
    - fr_err, or window expiry → wr_ptr := cm_ptr, frm_drop+1, go to IDLE.
    - crc_good and fr_err in the same cycle → drop.
  - DROP: ignore bytes until eof; then wr_ptr := cm_ptr, frm_drop+1, go to IDLE.
  - Full on a write attempt:
    - byte not written; ovf pulses once;
    - FSM goes to DROP, or straight to the rewind if this byte carried eof.
  - A commit makes the frame visible to the reader no earlier than the cycle after the cm_ptr update.
- Read side:
  - Read-ahead: RAM read is registered, feeding a 1-entry output register.
  - tvalid=1 whenever the output register holds a byte; register loads when rd_ptr != cm_ptr and (register empty or tvalid&tready).
  - Sustained 1 byte/cycle while tready=1.
  - First byte appears 2 cycles after commit.
  - tlast = stored eof_flag.
  - tdata/tlast held stable while tvalid&!tready.
  - rd_ptr never passes cm_ptr; rewinds never move rd_ptr.
  - Frame reads and writes proceed concurrently.
- Counters saturate at 16'hFFFF.
- Pointer wrap across the RAM end is seamless (modulo arithmetic).
- Reset mid-frame discards all content, including committed frames.

Test Plan:
- 64-byte frame (bytes 0x00..0x3F), crc_good 2 cycles after eof, tready=1 → 64 bytes out in order, tlast on 0x3F, frm_ok=1, frm_drop=0.
- Same frame, fr_err pulse on the eof cycle → no tvalid; frm_drop=1; next good 60-byte frame output intact.
- Frame with no status pulse → dropped 5 cycles after eof (STATUS_WAIT=4); no output.
- ADDR_W=6 (64 bytes), tready=0, 40-byte good frame then 40-byte frame → second frame dropped, ovf pulses once, frm_ok=1, frm_drop=1; release tready → only the first 40 bytes out.
- sof arriving mid-frame after 10 bytes → partial frame dropped, following frame committed and output.
- 30 back-to-back 100-byte good frames with random tready, ADDR_W=9 → exact byte/tlast order across pointer wrap, frm_ok=30; assert rstn mid-frame → tvalid=0 and counters=0 immediately.
